// File: rtl/seq_mul_ctrl_if.sv
// Operand/result bundle between a requester (CPU ALU side) and the
// sequential multiplier.
interface seq_mul_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, abort, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Shift-add unsigned multiplier sequencer: one add/shift step per clock,
// WIDTH steps per operation, one-cycle done pulse, result held until replaced.
module seq_mul_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mul_ctrl_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH-1:0] m_q,   m_d;
  logic [PW-1:0]    p_q,   p_d;
  logic [PW-1:0]    r_q,   r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    p_step_c;
  logic             last_step_c;

  // One add/shift step; the adder is WIDTH+1 bits so the carry shifts in.
  always_comb begin
    sum_c       = {1'b0, p_q[PW-1:WIDTH]} + ({1'b0, m_q} & {(WIDTH+1){p_q[0]}});
    p_step_c    = {sum_c, p_q[WIDTH-1:1]};
    last_step_c = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start && !bus.abort) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.abort)        state_nxt = S_IDLE;
        else if (last_step_c) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and flag next values; abort in RUN wins over the step.
  always_comb begin
    m_d    = m_q;
    p_d    = p_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = (state_nxt != S_IDLE);
    done_d = (state_nxt == S_DONE);
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          m_d   = bus.a;
          p_d   = {{WIDTH{1'b0}}, bus.b};
          cnt_d = '0;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          r_d = '0;
        end else begin
          p_d   = p_step_c;
          cnt_d = cnt_q + CW'(1);
          if (last_step_c) r_d = p_step_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      p_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      p_q    <= p_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = r_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboard bench for seq_mul_ctrl: driver pushes a*b expectations, a
// negedge monitor pops and compares on every done pulse.
module tb_seq_mul_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seq_mul_ctrl_if #(.WIDTH(32)) bus ();

  seq_mul_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'd0;
  int          n_vec    = 0;
  int          n_err    = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, required 0x%016h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", bus.product, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check(bus.product == e, "product", bus.product, e);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check(bus.busy == 1'b1, "accept_busy", 64'(bus.busy), 64'd1);
  endtask

  // Step through RUN; optional stray start (ignored) and abort at edge Ek.
  task automatic finish_op(input int stray_cyc, input int abort_cyc);
    bit seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == stray_cyc) begin
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
      end
      if (i == abort_cyc) bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (i == abort_cyc) begin
        last_res = 64'd0;
        check(!bus.busy && !bus.done, "abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        check(bus.product == 64'd0, "abort_product", bus.product, 64'd0);
        seen = 1'b1;
        break;
      end
      if (bus.done) begin
        check(i == 32, "latency", 64'(i), 64'd32);
        seen = 1'b1;
        break;
      end
      if (!bus.busy) begin
        check(1'b0, "busy_dropped", 64'(i), 64'd32);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(1'b0, "done_timeout", 64'd40, 64'd32);
    @(posedge clk);
    #1;
    check(!bus.busy && !bus.done, "idle_after", {62'd0, bus.busy, bus.done}, 64'd0);
    check(bus.product == last_res, "hold", bus.product, last_res);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int stray_cyc, input int abort_cyc);
    if (abort_cyc == 0) begin
      exp_q.push_back(ref_mul(a, b));
      last_res = ref_mul(a, b);
    end
    issue(a, b);
    finish_op(stray_cyc, abort_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1 rst_n = 1'b0;
    #1;
    check(!bus.busy && !bus.done, "reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    check(bus.product == 64'd0, "reset_product", bus.product, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op(32'd3, 32'd5, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(32'h8000_0000, 32'd2, 0, 0);

    run_op(32'd0, 32'h1234_5678, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check(bus.product == 64'd0 && !bus.done, "idle_hold", bus.product, 64'd0);
    end

    run_op(32'd7, 32'd9, 10, 0);

    // Start held through DONE is only taken at the first IDLE edge.
    exp_q.push_back(ref_mul(32'd21, 32'd4));
    issue(32'd21, 32'd4);
    repeat (31) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    check(bus.done == 1'b1, "done_at_e32", 64'(bus.done), 64'd1);
    @(posedge clk);
    #1;
    check(bus.busy == 1'b0, "start_ignored_in_done", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check(bus.busy == 1'b1, "start_at_first_idle", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    exp_q.push_back(ref_mul(32'd100, 32'd3));
    last_res = ref_mul(32'd100, 32'd3);
    finish_op(0, 0);

    run_op(32'h0000_1000, 32'h10, 0, 10);
    run_op(32'd6, 32'd7, 0, 0);

    // Asynchronous reset between edges in the middle of RUN.
    issue(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check(!bus.busy && !bus.done, "async_rst_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    check(bus.product == 64'd0, "async_rst_product", bus.product, 64'd0);
    last_res = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(32'd11, 32'd13, 0, 0);

    for (int n = 0; n < 25; n++) begin
      logic [31:0] ra, rb;
      int          ab, st;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'd0;
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0;
      st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 31)) : 0;
      run_op(ra, rb, st, ab);
    end

    repeat (5) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "pending_results", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mul_ctrl.md
# seq_mul_ctrl

Sequencer for a 32x32 unsigned shift-add multiplier built around a 64-bit product register, a 32-bit multiplicand register and a 6-bit iteration counter. It accepts one operand pair per start pulse and runs one add/shift step per clock. It raises a one-cycle done pulse and holds the 64-bit result until the next accepted operation. It sits beside the CPU ALU as the multi-cycle multiply unit.

## Interface
- WIDTH, 32: operand width; the product is 2*WIDTH bits. Only 32 is verified.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  cancel an in-flight multiply; sampled in RUN and IDLE.
- a  input  32  multiplicand; captured on the accepting edge.
- b  input  32  multiplier; captured on the accepting edge.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; high exactly while in DONE.
- product  output  64  registered result; changes only on entry to DONE, on abort, or on reset.

## Operation
- Reset is asynchronous and active-low (rst_n) on one clock (clk). While rst_n=0: state=IDLE, busy=0, done=0, product=0, counter=0, internal registers=0.
- Internal registers:
  - M[31:0]: multiplicand.
  - P[63:0]: working product.
  - cnt[5:0]: iteration counter.
  - R[63:0]: result register, which drives product.
- States:
  - IDLE:
    - start=1 and abort=0: M<=a, P<={32'b0,b}, cnt<=0, go to RUN.
    - Otherwise stay. abort=1 in IDLE overrides start; nothing is captured.
  - RUN, one step per edge:
    - If P[0]=1: s[32:0] = {1'b0,P[63:32]} + {1'b0,M}. If P[0]=0: s = {1'b0,P[63:32]}.
    - P <= {s[32:0], P[31:1]}. This is a 33-bit sum followed by a logical right shift; the carry is never lost.
    - cnt <= cnt+1. When cnt==31 at the edge, the step is performed, R is loaded with the step's new P value, and the state goes to DONE.
    - abort=1 in RUN: no step is performed; go to IDLE and clear R to 0. done is not asserted.
  - DONE: done=1 for this cycle only. The state goes to IDLE unconditionally on the next edge. start and abort are ignored in DONE.
- start while busy=1 is ignored and not queued.
- a and b are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- R holds its value in IDLE indefinitely. It is overwritten only by the next completion, by an abort, or by reset.
- Arithmetic is unsigned modulo nothing: the full 64-bit product is always exact.

## Timing
- Edge E0: start accepted in IDLE. busy=1 from after E0.
- Edges E1..E32: 32 RUN steps. The step at E32 has cnt==31.
- After E32: state=DONE, done=1, product=a*b.
- After E33: state=IDLE, busy=0, done=0, product holds.
- Latency from the accepting edge to done high is 32 cycles. done is high for exactly 1 cycle.
- Minimum issue interval is 34 cycles: a new start is first accepted at E34, the first edge in IDLE.
- Abort sampled high at any RUN edge Ek: after Ek the state is IDLE, busy=0, product=0, and there is no done pulse. A start may be accepted at E(k+1).
- rst_n asserted mid-operation: immediate return to the reset values with no done pulse. Operation resumes at the first start after rst_n deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic multiply: reset, then start with a=3, b=5 → done rises exactly 32 cycles after the accepting edge, product=0x000000000000000F. busy is high for 33 cycles.
- Carry stress: a=0xFFFFFFFF, b=0xFFFFFFFF → product=0xFFFFFFFE00000001. Repeat with a=0x80000000, b=2 → product=0x0000000100000000.
- Zero operands and hold: a=0, b=0x12345678 → product=0 and done pulses once. Then idle for 10 cycles → product stays 0 and done stays 0.
- Ignored start: a start with a=7, b=9 is accepted. A second start with a=2, b=2 is pulsed at cycle 10 → only one done, product=63. A start held high during DONE is not accepted; the next op begins at the first IDLE edge.
- Abort: a=0x1000, b=0x10 is accepted and abort is pulsed at cycle 10 → busy=0 next cycle, product=0, no done. A new start with a=6, b=7 then yields product=42.
- Async reset: rst_n is pulled low mid-RUN between clock edges → busy, done and product go to 0 immediately without a clock edge. After release, a=11, b=13 → product=143.
